ro_freq_compare: RTL and testbench
==================================

Name: ro_freq_compare

Overview:
- Downstream consumer of the two 16-RO banks; sequential measurement stage.
- Picks one RO from bank 1 and one from bank 2, enables both banks, and waits a settle period.
- Counts rising edges of each selected RO over a programmable gate window.
- Produces a comparison response bit (PUF/sensor style) plus both raw counts, via a start/done handshake.

Parameters:
- NUM_RO, 16, ROs per bank; width of each ro*_in bus.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= NUM_RO.
- CNT_W, 16, edge-counter width; counters saturate.
- WIN_W, 16, gate-window length register width.
- SETTLE_CYC, 8, cycles between RO enable and start of counting (min 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- sel_a  in  SEL_W  bank-1 RO index; latched on accepted start.
- sel_b  in  SEL_W  bank-2 RO index; latched on accepted start.
- window  in  WIN_W  count window in clk cycles; latched on accepted start.
- ro1_in  in  NUM_RO  bank-1 RO outputs; asynchronous.
- ro2_in  in  NUM_RO  bank-2 RO outputs; asynchronous.
- ro_activate_1  out  1  bank-1 enable.
- ro_activate_2  out  1  bank-2 enable.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when results update.
- count_a  out  CNT_W  bank-1 edge count of last measurement.
- count_b  out  CNT_W  bank-2 edge count of last measurement.
- resp_bit  out  1  1 iff count_a > count_b.
- tie  out  1  1 iff count_a == count_b.

Behaviour:
- Reset: state IDLE. All outputs 0: ro_activate_*, busy, done, count_a, count_b, resp_bit, tie. Synchronizer and internal counters cleared.
- Reset mid-operation: abort in the same cycle; ROs deactivated next edge; results cleared; no done pulse.
- Input conditioning: selected RO bit → 2-flop synchronizer → edge-detect flop. A rising edge is the synchronized value 1 with the previous value 0.
- Input conditioning, index range: index >= NUM_RO selects constant 0, giving count 0.
- Input conditioning, frequency limit: RO frequency must be < clk/2 for exact counts.
- IDLE: busy=0. start=1 latches sel_a, sel_b, window → SETTLE. start in any other state is ignored.
- SETTLE: ro_activate_1 = ro_activate_2 = 1. Settle counter runs SETTLE_CYC cycles. Edge counters held at 0. At the end → COUNT, or → DONE directly if latched window==0.
- COUNT: activates stay 1. Each detected rising edge increments its counter, saturating at 2**CNT_W-1. Lasts exactly `window` cycles → DONE.
- DONE, single cycle:
  - Activates drop to 0.
  - count_a/b, resp_bit and tie registered from the final counts.
  - done=1 for this cycle; → IDLE.
- Result hold: outputs hold until the next DONE or rst.
- Timing: start sampled at cycle T → activates high T+1 → counting over cycles T+1+SETTLE_CYC .. T+SETTLE_CYC+window → done at T+SETTLE_CYC+window+1 (results valid the same cycle).
- Edge-capture boundary: edges within the last 2 cycles before COUNT exit may be lost to synchronizer latency (±1 count tolerance). Edges during SETTLE are never counted.
- Comparison: unsigned compare of saturated counts; saturation on both sides gives tie=1, resp_bit=0.

Optional Feature:
- Macro RO_CMP_DIFF_EN.
- Defined: adds output port diff (CNT_W+1 bits), the two's-complement count_a − count_b. It is registered in DONE together with the counts and is 0 on reset.
- Undefined: no diff port and no subtractor logic; all other behaviour identical.

Test Plan:
- Window 800, SETTLE_CYC 8:
  - ro1_in[3] toggles every 4 clk (period 8); ro2_in[5] period 10; sel_a=3, sel_b=5.
  - count_a=100±1, count_b=80±1, resp_bit=1, tie=0.
  - done exactly 809 cycles after the start cycle.
- Swap: sel_a=5 on a period-10 wave, sel_b=3 on a period-8 wave, window 800 → resp_bit=0, tie=0. Identical waveforms on both selects → tie=1, resp_bit=0.
- window=0 → done SETTLE_CYC+1 cycles after start; counts 0; tie=1. start pulsed while busy → ignored, latched selects and window unchanged.
- CNT_W=4 build, period-4 input, window 200 → count saturates at 15; the other side idle (0) → resp_bit=1.
- rst asserted mid-COUNT → next cycle busy=0, activates 0, counts 0, no done pulse. A new start after that completes normally.
- RO_CMP_DIFF_EN defined, first scenario → diff = +20±2. Swapped scenario → diff = −20±2.

Source files
------------

// File: rtl/ro_freq_compare.sv
// Ring-oscillator frequency comparator: counts rising edges of one RO from each bank
// over a programmable gate window and reports both counts plus a comparison bit.
// Optional feature: define RO_CMP_DIFF_EN to add the signed count difference output 'diff'.
module ro_freq_compare #(
  parameter int NUM_RO     = 16,
  parameter int SEL_W      = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  input  logic [WIN_W-1:0]  window,
  input  logic [NUM_RO-1:0] ro1_in,
  input  logic [NUM_RO-1:0] ro2_in,
  output logic              ro_activate_1,
  output logic              ro_activate_2,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count_a,
  output logic [CNT_W-1:0]  count_b,
  output logic              resp_bit,
`ifdef RO_CMP_DIFF_EN
  output logic [CNT_W:0]    diff,
`endif
  output logic              tie
);

  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [SEL_W-1:0]  sel_a_q, sel_b_q;
  logic [WIN_W-1:0]  window_q, win_cnt_q;
  logic [ST_W-1:0]   settle_q;
  logic [1:0]        sync_a_q, sync_b_q;
  logic              prev_a_q, prev_b_q;
  logic [CNT_W-1:0]  cnt_a_q, cnt_b_q;
  logic [CNT_W-1:0]  cnt_a_d, cnt_b_d;
  logic              ro_a, ro_b, rise_a, rise_b;
  logic              settle_end, win_end, finish;

  // Indices beyond NUM_RO match no bank bit and leave the selected RO at constant 0.
  always_comb begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (sel_a_q == SEL_W'(i)) ro_a = ro1_in[i];
      if (sel_b_q == SEL_W'(i)) ro_b = ro2_in[i];
    end
  end

  assign rise_a = sync_a_q[1] & ~prev_a_q;
  assign rise_b = sync_b_q[1] & ~prev_b_q;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (state_q == S_COUNT) begin
      if (rise_a && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (rise_b && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_W'(1);
    end
  end

  assign settle_end = (state_q == S_SETTLE) && (settle_q == ST_W'(SETTLE_CYC - 1));
  assign win_end    = (state_q == S_COUNT) && (win_cnt_q == window_q - WIN_W'(1));
  assign finish     = win_end || (settle_end && window_q == '0);

  // NOTE: every flop here uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      prev_a_q <= 1'b0;
      prev_b_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[0], ro_a};
      sync_b_q <= {sync_b_q[0], ro_b};
      prev_a_q <= sync_a_q[1];
      prev_b_q <= sync_b_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sel_a_q       <= '0;
      sel_b_q       <= '0;
      window_q      <= '0;
      win_cnt_q     <= '0;
      settle_q      <= '0;
      cnt_a_q       <= '0;
      cnt_b_q       <= '0;
      ro_activate_1 <= 1'b0;
      ro_activate_2 <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      count_a       <= '0;
      count_b       <= '0;
      resp_bit      <= 1'b0;
      tie           <= 1'b0;
`ifdef RO_CMP_DIFF_EN
      diff          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sel_a_q       <= sel_a;
            sel_b_q       <= sel_b;
            window_q      <= window;
            settle_q      <= '0;
            win_cnt_q     <= '0;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            ro_activate_1 <= 1'b1;
            ro_activate_2 <= 1'b1;
            busy          <= 1'b1;
            state_q       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          settle_q <= settle_q + ST_W'(1);
          if (settle_end && window_q != '0) state_q <= S_COUNT;
        end
        S_COUNT: begin
          cnt_a_q   <= cnt_a_d;
          cnt_b_q   <= cnt_b_d;
          win_cnt_q <= win_cnt_q + WIN_W'(1);
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Results are taken from the next-state counts so the final window cycle is included.
      if (finish) begin
        count_a       <= cnt_a_d;
        count_b       <= cnt_b_d;
        resp_bit      <= (cnt_a_d > cnt_b_d);
        tie           <= (cnt_a_d == cnt_b_d);
`ifdef RO_CMP_DIFF_EN
        diff          <= {1'b0, cnt_a_d} - {1'b0, cnt_b_d};
`endif
        ro_activate_1 <= 1'b0;
        ro_activate_2 <= 1'b0;
        done          <= 1'b1;
        state_q       <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_compare.sv
// Randomized bench for ro_freq_compare: RO waveforms are generated from per-bit half-periods
// and the expected counts are derived by counting waveform rises inside the gate window.
module tb_ro_freq_compare;

  localparam int NUM_RO     = 16;
  localparam int SEL_W      = 4;
  localparam int CNT_W      = 16;
  localparam int WIN_W      = 16;
  localparam int SETTLE_CYC = 8;
  localparam int SCNT_W     = 4;
  localparam int SMAX       = (1 << SCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [SEL_W-1:0]  sel_a, sel_b;
  logic [WIN_W-1:0]  window;
  logic [NUM_RO-1:0] ro1_in, ro2_in;

  logic              act1, act2, busy, done, resp_bit, tie;
  logic [CNT_W-1:0]  count_a, count_b;
  logic              s_act1, s_act2, s_busy, s_done, s_resp, s_tie;
  logic [SCNT_W-1:0] s_count_a, s_count_b;
`ifdef RO_CMP_DIFF_EN
  logic [CNT_W:0]    diff;
  logic [SCNT_W:0]   s_diff;
`endif

  ro_freq_compare #(.NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W),
                    .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b), .window(window),
    .ro1_in(ro1_in), .ro2_in(ro2_in), .ro_activate_1(act1), .ro_activate_2(act2),
    .busy(busy), .done(done), .count_a(count_a), .count_b(count_b), .resp_bit(resp_bit),
`ifdef RO_CMP_DIFF_EN
    .diff(diff),
`endif
    .tie(tie)
  );

  ro_freq_compare #(.NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(SCNT_W), .WIN_W(WIN_W),
                    .SETTLE_CYC(SETTLE_CYC)) dut_s (
    .clk(clk), .rst(rst), .start(start), .sel_a(sel_a), .sel_b(sel_b), .window(window),
    .ro1_in(ro1_in), .ro2_in(ro2_in), .ro_activate_1(s_act1), .ro_activate_2(s_act2),
    .busy(s_busy), .done(s_done), .count_a(s_count_a), .count_b(s_count_b), .resp_bit(s_resp),
`ifdef RO_CMP_DIFF_EN
    .diff(s_diff),
`endif
    .tie(s_tie)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int v, input int lo, input int hi);
    check($sformatf("%s=%0d in [%0d,%0d]", tag, v, lo, hi), 64'(v >= lo && v <= hi), 64'd1);
  endtask

  // Waveform model: per-bit half-period (0 = stuck low) and phase, indexed by bench cycle.
  int h1[NUM_RO], h2[NUM_RO], p1[NUM_RO], p2[NUM_RO];
  int gcyc = 0;

  function automatic bit wave(input int h, input int ph, input int c);
    if (h == 0) return 1'b0;
    return ((c + ph) / h) % 2 == 1;
  endfunction

  function automatic int rises(input int h, input int ph, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++)
      if (wave(h, ph, c) && !wave(h, ph, c - 1)) n++;
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      gcyc++;
      for (int i = 0; i < NUM_RO; i++) begin
        ro1_in[i] = wave(h1[i], p1[i], gcyc);
        ro2_in[i] = wave(h2[i], p2[i], gcyc);
      end
    end
  end

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Launch one measurement, optionally pulse start again while busy, and check the handshake.
  task automatic run(input string name, input int sa, input int sb, input int win,
                     input int poke_at, output int ea, output int eb, output bit same);
    int g0, lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; sel_a = SEL_W'(sa); sel_b = SEL_W'(sb); window = WIN_W'(win);
    g0   = gcyc;
    ea   = (sa < NUM_RO) ? rises(h1[sa], p1[sa], g0 + SETTLE_CYC + 1, g0 + SETTLE_CYC + win) : 0;
    eb   = (sb < NUM_RO) ? rises(h2[sb], p2[sb], g0 + SETTLE_CYC + 1, g0 + SETTLE_CYC + win) : 0;
    same = (h1[sa] == h2[sb]) && (h1[sa] == 0 || p1[sa] == p2[sb]);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < win + SETTLE_CYC + 50) begin
      @(negedge clk);
      lat++;
      start = (lat == poke_at);
      if (lat == poke_at) begin
        sel_a  = SEL_W'(sa + 1);
        sel_b  = SEL_W'(sb + 1);
        window = WIN_W'(3);
      end
      if (lat == 1) begin
        check({name, " act1 after start"}, 64'(act1), 64'd1);
        check({name, " act2 after start"}, 64'(act2), 64'd1);
        check({name, " busy after start"}, 64'(busy), 64'd1);
      end
      if (done) seen = 1'b1;
    end
    check({name, " done seen"}, 64'(seen), 64'd1);
    check({name, " done latency"}, 64'(lat), 64'(win + SETTLE_CYC + 1));
    check({name, " small done aligned"}, 64'(s_done), 64'd1);
    check({name, " act1 low in done"}, 64'(act1), 64'd0);
    check({name, " busy in done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({name, " done one cycle"}, 64'(done), 64'd0);
    check({name, " idle after done"}, 64'(busy), 64'd0);
  endtask

  // Compare both instances against the model counts (+-1 for synchronizer edge effects).
  task automatic check_results(input string name, input int ea, input int eb, input bit same);
    int alo, ahi, blo, bhi;
    alo = clampi(ea - 1, 0, 65535); ahi = ea + 1;
    blo = clampi(eb - 1, 0, 65535); bhi = eb + 1;
    check_rng({name, " count_a"}, int'(count_a), alo, ahi);
    check_rng({name, " count_b"}, int'(count_b), blo, bhi);
    if (same) begin
      check({name, " tie"}, 64'(tie), 64'd1);
      check({name, " resp"}, 64'(resp_bit), 64'd0);
    end else if (ea - eb >= 3) begin
      check({name, " tie"}, 64'(tie), 64'd0);
      check({name, " resp"}, 64'(resp_bit), 64'd1);
    end else if (eb - ea >= 3) begin
      check({name, " tie"}, 64'(tie), 64'd0);
      check({name, " resp"}, 64'(resp_bit), 64'd0);
    end
`ifdef RO_CMP_DIFF_EN
    check_rng({name, " diff"}, int'($signed(diff)), alo - bhi, ahi - blo);
`endif
    alo = clampi(alo, 0, SMAX); ahi = clampi(ahi, 0, SMAX);
    blo = clampi(blo, 0, SMAX); bhi = clampi(bhi, 0, SMAX);
    check_rng({name, " s_count_a"}, int'(s_count_a), alo, ahi);
    check_rng({name, " s_count_b"}, int'(s_count_b), blo, bhi);
    if (same || (alo == SMAX && blo == SMAX)) begin
      check({name, " s_tie"}, 64'(s_tie), 64'd1);
      check({name, " s_resp"}, 64'(s_resp), 64'd0);
    end else if (alo > bhi) begin
      check({name, " s_tie"}, 64'(s_tie), 64'd0);
      check({name, " s_resp"}, 64'(s_resp), 64'd1);
    end else if (blo > ahi) begin
      check({name, " s_tie"}, 64'(s_tie), 64'd0);
      check({name, " s_resp"}, 64'(s_resp), 64'd0);
    end
`ifdef RO_CMP_DIFF_EN
    check_rng({name, " s_diff"}, int'($signed(s_diff)), alo - bhi, ahi - blo);
`endif
  endtask

  task automatic check_cleared(input string name);
    check({name, " busy"}, 64'(busy), 64'd0);
    check({name, " act1"}, 64'(act1), 64'd0);
    check({name, " act2"}, 64'(act2), 64'd0);
    check({name, " done"}, 64'(done), 64'd0);
    check({name, " count_a"}, 64'(count_a), 64'd0);
    check({name, " count_b"}, 64'(count_b), 64'd0);
    check({name, " resp"}, 64'(resp_bit), 64'd0);
    check({name, " tie"}, 64'(tie), 64'd0);
    check({name, " s_count_a"}, 64'(s_count_a), 64'd0);
`ifdef RO_CMP_DIFF_EN
    check({name, " diff"}, 64'(diff), 64'd0);
`endif
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb, sa, sb, win;
    bit same, stray;
    rst = 1'b1; start = 1'b0; sel_a = '0; sel_b = '0; window = '0;
    ro1_in = '0; ro2_in = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      h1[i] = 7 + (i % 4); h2[i] = 8 + (i % 3); p1[i] = i; p2[i] = 2 * i;
    end
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Period 8 on bank-1 bit 3 vs period 10 on bank-2 bit 5; a start pulse mid-run is ignored.
    h1[3] = 4; p1[3] = 0; h2[5] = 5; p2[5] = 0;
    run("s1", 3, 5, 800, 100, ea, eb, same);
    check_rng("s1 model count_a", ea, 99, 101);
    check_results("s1", ea, eb, same);
    repeat (5) @(negedge clk);
    check_rng("s1 hold count_a", int'(count_a), 99, 101);

    h1[5] = 5; p1[5] = 0; h2[3] = 4; p2[3] = 0;
    run("swap", 5, 3, 800, 0, ea, eb, same);
    check_results("swap", ea, eb, same);

    run("same", 3, 3, 300, 0, ea, eb, same);
    check_results("same", ea, eb, same);

    run("win0", 3, 5, 0, 4, ea, eb, same);
    check("win0 count_a", 64'(count_a), 64'd0);
    check("win0 tie", 64'(tie), 64'd1);
    check("win0 resp", 64'(resp_bit), 64'd0);

    // Fastest legal input on side a against an idle side b.
    h1[7] = 2; p1[7] = 1; h2[9] = 0;
    run("sat", 7, 9, 200, 0, ea, eb, same);
    check_results("sat", ea, eb, same);
    check("sat s_count_a", 64'(s_count_a), 64'(SMAX));
    check("sat s_resp", 64'(s_resp), 64'd1);

    // Reset in the middle of COUNT aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; sel_a = 4'd3; sel_b = 4'd5; window = WIN_W'(800);
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst busy before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("midrst");
    stray = 1'b0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (done || busy) stray = 1'b1;
    end
    check("midrst no done/busy after abort", 64'(stray), 64'd0);
    run("post_rst", 3, 5, 400, 0, ea, eb, same);
    check_results("post_rst", ea, eb, same);

    for (int k = 0; k < 6; k++) begin
      sa  = $urandom_range(0, NUM_RO - 1);
      sb  = $urandom_range(0, NUM_RO - 1);
      win = $urandom_range(20, 400);
      h1[sa] = $urandom_range(2, 12); p1[sa] = $urandom_range(0, 23);
      h2[sb] = $urandom_range(2, 12); p2[sb] = $urandom_range(0, 23);
      run($sformatf("rand%0d", k), sa, sb, win, 0, ea, eb, same);
      check_results($sformatf("rand%0d", k), ea, eb, same);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
